// File: rtl/quad_decode.sv
// -----------------------------------------------------------------------------
// quad_decode
//
// Quadrature encoder decoder with input synchronisation, per-channel glitch
// filtering, step decoding, a wrapping signed position counter and a sticky
// illegal-transition flag.
//
// Ports
//   clk_in      input              single clock for all logic
//   rst_in      input              asynchronous, active-low reset
//   a_in        input              encoder channel A (asynchronous to clk_in)
//   b_in        input              encoder channel B (asynchronous to clk_in)
//   enable_in   input              counting enable
//   err_clr_in  input              clears the sticky error flag
//   inc         output             one-cycle pulse per forward step
//   dec         output             one-cycle pulse per reverse step
//   position    output [POS_WIDTH] signed step count, two's complement, wraps
//   dir_out     output             direction of last counted step, 1 = forward
//   err_out     output             sticky illegal-transition flag
//
// Latency from a clean input edge to inc/dec is SYNC_STAGES + FILTER_CYCLES + 1.
// -----------------------------------------------------------------------------
module quad_decode #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int POS_WIDTH     = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        a_in,
  input  logic                        b_in,
  input  logic                        enable_in,
  input  logic                        err_clr_in,
  output logic                        inc,
  output logic                        dec,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        dir_out,
  output logic                        err_out
);

  localparam int             CNT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  // Position of an {A,B} code along the forward Gray sequence 00,01,11,10.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    logic [1:0] idx;
    case (ab)
      2'b00:   idx = 2'd0;
      2'b01:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // One step up or down; overflow wraps modulo 2^POS_WIDTH without a flag.
  function automatic logic signed [POS_WIDTH-1:0] wrap_step(
    input logic signed [POS_WIDTH-1:0] p,
    input logic                        up
  );
    return up ? (p + POS_WIDTH'(1)) : (p - POS_WIDTH'(1));
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: input synchronisers. sync_vld_p0 fills with ones after reset so
  // the priming logic knows when the chain output reflects the real inputs.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] a_sync_p0;
  logic [SYNC_STAGES-1:0] b_sync_p0;
  logic [SYNC_STAGES-1:0] sync_vld_p0;
  logic [1:0]             ab_sync_p0;
  logic                   vld_p0;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      a_sync_p0   <= '0;
      b_sync_p0   <= '0;
      sync_vld_p0 <= '0;
    end else begin
      a_sync_p0   <= {a_sync_p0[SYNC_STAGES-2:0], a_in};
      b_sync_p0   <= {b_sync_p0[SYNC_STAGES-2:0], b_in};
      sync_vld_p0 <= {sync_vld_p0[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign ab_sync_p0 = {a_sync_p0[SYNC_STAGES-1], b_sync_p0[SYNC_STAGES-1]};
  assign vld_p0     = sync_vld_p0[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Stage p1: per-channel stability filter. Bit 1 is channel A, bit 0 is B.
  // A channel's filtered value only follows the synchronised value after it
  // has differed for FILTER_CYCLES consecutive cycles.
  // ---------------------------------------------------------------------------
  logic [1:0]       ab_filt_p1;
  logic [CNT_W-1:0] filt_cnt_p1 [2];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ab_filt_p1     <= '0;
      filt_cnt_p1[0] <= '0;
      filt_cnt_p1[1] <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (ab_sync_p0[ch] == ab_filt_p1[ch]) begin
          filt_cnt_p1[ch] <= '0;
        end else if (filt_cnt_p1[ch] == CNT_LAST) begin
          ab_filt_p1[ch]  <= ab_sync_p0[ch];
          filt_cnt_p1[ch] <= '0;
        end else begin
          filt_cnt_p1[ch] <= filt_cnt_p1[ch] + 1'b1;
        end
      end
    end
  end

  // Step classification from the Gray-index distance between the filtered
  // code and the previously accepted one: +1 forward, -1 reverse, 2 illegal.
  logic [1:0] ab_state_p2;
  logic [1:0] delta_p1;
  logic       evt_p1;
  logic       fwd_p1;
  logic       rev_p1;
  logic       ill_p1;
  logic       settled_p1;
  logic       primed_p2;

  always_comb begin
    delta_p1   = gray_idx(ab_filt_p1) - gray_idx(ab_state_p2);
    evt_p1     = (ab_filt_p1 != ab_state_p2);
    fwd_p1     = evt_p1 && (delta_p1 == 2'd1);
    rev_p1     = evt_p1 && (delta_p1 == 2'd3);
    ill_p1     = evt_p1 && (delta_p1 == 2'd2);
    // Inputs have propagated through the synchronisers and both filters agree
    // with them, so the filtered code is a trustworthy reference.
    settled_p1 = vld_p0 && (ab_sync_p0 == ab_filt_p1);
  end

  // ---------------------------------------------------------------------------
  // Stage p2: state register, output pulses, position, direction, error.
  // Until primed, decode events only update the reference state; this keeps
  // the code seen at reset release from being counted or flagged.
  // ---------------------------------------------------------------------------
  logic                        inc_p2;
  logic                        dec_p2;
  logic signed [POS_WIDTH-1:0] pos_p2;
  logic                        dir_p2;
  logic                        err_p2;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ab_state_p2 <= '0;
      primed_p2   <= 1'b0;
      inc_p2      <= 1'b0;
      dec_p2      <= 1'b0;
      pos_p2      <= '0;
      dir_p2      <= 1'b0;
      err_p2      <= 1'b0;
    end else begin
      inc_p2 <= 1'b0;
      dec_p2 <= 1'b0;

      if (evt_p1) begin
        ab_state_p2 <= ab_filt_p1;
      end

      if (!primed_p2 && settled_p1) begin
        primed_p2 <= 1'b1;
      end

      // Disabled steps still move the state register but are dropped here.
      if (primed_p2 && enable_in && (fwd_p1 || rev_p1)) begin
        inc_p2 <= fwd_p1;
        dec_p2 <= rev_p1;
        pos_p2 <= wrap_step(pos_p2, fwd_p1);
        dir_p2 <= fwd_p1;
      end

      // A new illegal step takes priority over a concurrent clear.
      if (primed_p2 && ill_p1) begin
        err_p2 <= 1'b1;
      end else if (err_clr_in) begin
        err_p2 <= 1'b0;
      end
    end
  end

  assign inc      = inc_p2;
  assign dec      = dec_p2;
  assign position = pos_p2;
  assign dir_out  = dir_p2;
  assign err_out  = err_p2;

endmodule

// File: tb/tb_quad_decode.sv
module tb_quad_decode;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        a_in = 1'b0;
  logic        b_in = 1'b0;
  logic        enable_in = 1'b1;
  logic        err_clr_in = 1'b0;
  logic        inc;
  logic        dec;
  logic [15:0] position;
  logic        dir_out;
  logic        err_out;

  quad_decode #(
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(4),
    .POS_WIDTH    (16)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .enable_in (enable_in),
    .err_clr_in(err_clr_in),
    .inc       (inc),
    .dec       (dec),
    .position  (position),
    .dir_out   (dir_out),
    .err_out   (err_out)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [1:0]  kind;   // {inc,dec} pattern expected
    logic [15:0] pos;
    logic        dir;
    int unsigned due;
  } exp_t;

  exp_t sb[$];

  logic [15:0] exp_pos = 16'h0000;
  logic        exp_dir = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  // Monitor: every inc/dec pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk_in);
      if (inc || dec) begin
        if (sb.size() == 0) begin
          chk("spurious_pulse", {30'd0, inc, dec}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pulse_kind", {30'd0, inc, dec}, {30'd0, e.kind});
          chk("pulse_cycle", cyc, e.due);
          chk("pulse_pos", {16'd0, position}, {16'd0, e.pos});
          chk("pulse_dir", {31'd0, dir_out}, {31'd0, e.dir});
        end
      end
    end
  end

  // kind: 0 = no pulse expected, 1 = inc, 2 = dec. Pulse due 7 cycles later.
  task automatic step(input logic [1:0] ab, input int kind);
    exp_t e;
    @(negedge clk_in);
    {a_in, b_in} = ab;
    if (kind == 1) begin
      exp_pos = exp_pos + 16'd1;
      exp_dir = 1'b1;
    end else if (kind == 2) begin
      exp_pos = exp_pos - 16'd1;
      exp_dir = 1'b0;
    end
    if (kind != 0) begin
      e.kind = (kind == 1) ? 2'b10 : 2'b01;
      e.pos  = exp_pos;
      e.dir  = exp_dir;
      e.due  = cyc + 7;
      sb.push_back(e);
    end
    repeat (19) @(negedge clk_in);
  endtask

  task automatic reset_pulse();
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    exp_pos = 16'h0000;
    exp_dir = 1'b0;
  endtask

  logic [1:0] fwd_seq [8];
  int unsigned t0;

  initial begin
    fwd_seq[0] = 2'b01; fwd_seq[1] = 2'b11; fwd_seq[2] = 2'b10; fwd_seq[3] = 2'b00;
    fwd_seq[4] = 2'b01; fwd_seq[5] = 2'b11; fwd_seq[6] = 2'b10; fwd_seq[7] = 2'b00;

    #1 rst_in = 1'b0;
    #1;
    chk("rst_pos", {16'd0, position}, 32'd0);
    chk("rst_err", {31'd0, err_out}, 32'd0);
    chk("rst_pulse", {30'd0, inc, dec}, 32'd0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (10) @(negedge clk_in);

    // Eight forward steps.
    for (int i = 0; i < 8; i++) step(fwd_seq[i], 1);
    chk("fwd_pos", {16'd0, position}, 32'h0008);
    chk("fwd_dir", {31'd0, dir_out}, 32'd1);
    chk("fwd_drain", sb.size(), 32'd0);

    // Asynchronous reset mid-cycle clears state without a clock edge.
    @(posedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    chk("async_rst_pos", {16'd0, position}, 32'd0);
    chk("async_rst_dir", {31'd0, dir_out}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    exp_pos = 16'h0000;
    exp_dir = 1'b0;
    repeat (10) @(negedge clk_in);

    // Three reverse steps from zero.
    step(2'b10, 2);
    step(2'b11, 2);
    step(2'b01, 2);
    chk("rev_pos", {16'd0, position}, 32'hFFFD);
    chk("rev_dir", {31'd0, dir_out}, 32'd0);
    chk("rev_drain", sb.size(), 32'd0);

    // Three-cycle glitch on A (01 -> 11 -> 01) must be filtered away.
    @(negedge clk_in);
    a_in = 1'b1;
    repeat (3) @(negedge clk_in);
    a_in = 1'b0;
    repeat (20) @(negedge clk_in);
    chk("glitch_pos", {16'd0, position}, 32'hFFFD);
    chk("glitch_err", {31'd0, err_out}, 32'd0);

    // Illegal 01 -> 10 step.
    step(2'b10, 0);
    chk("ill_err", {31'd0, err_out}, 32'd1);
    chk("ill_pos", {16'd0, position}, 32'hFFFD);
    @(negedge clk_in);
    err_clr_in = 1'b1;
    @(negedge clk_in);
    err_clr_in = 1'b0;
    chk("clr_err", {31'd0, err_out}, 32'd0);

    // Illegal 10 -> 01 step with err_clr_in high on the same edge.
    @(negedge clk_in);
    {a_in, b_in} = 2'b01;
    t0 = cyc;
    while (cyc != t0 + 6) @(negedge clk_in);
    chk("pre_set_err", {31'd0, err_out}, 32'd0);
    err_clr_in = 1'b1;
    @(negedge clk_in);
    err_clr_in = 1'b0;
    chk("set_wins_err", {31'd0, err_out}, 32'd1);
    repeat (15) @(negedge clk_in);
    chk("set_hold_err", {31'd0, err_out}, 32'd1);
    chk("ill2_pos", {16'd0, position}, 32'hFFFD);
    @(negedge clk_in);
    err_clr_in = 1'b1;
    @(negedge clk_in);
    err_clr_in = 1'b0;

    // Wrap around the signed range.
    force dut.pos_p2 = 16'sh7FFF;
    @(posedge clk_in);
    #1 release dut.pos_p2;
    exp_pos = 16'h7FFF;
    @(negedge clk_in);
    chk("preload_pos", {16'd0, position}, 32'h7FFF);
    step(2'b11, 1);
    chk("wrap_up_pos", {16'd0, position}, 32'h8000);
    step(2'b01, 2);
    step(2'b00, 2);
    chk("wrap_dn_pos", {16'd0, position}, 32'h7FFE);
    chk("wrap_drain", sb.size(), 32'd0);

    // Reset released with inputs at 11: priming takes 11 as the reference.
    @(negedge clk_in);
    {a_in, b_in} = 2'b11;
    reset_pulse();
    repeat (20) @(negedge clk_in);
    chk("prime_err", {31'd0, err_out}, 32'd0);
    chk("prime_pos", {16'd0, position}, 32'd0);

    // Disabled steps track state but are discarded.
    enable_in = 1'b0;
    step(2'b10, 0);
    step(2'b00, 0);
    chk("dis_pos", {16'd0, position}, 32'd0);
    chk("dis_dir", {31'd0, dir_out}, 32'd0);
    enable_in = 1'b1;
    step(2'b01, 1);
    chk("ena_pos", {16'd0, position}, 32'd1);
    step(2'b00, 2);
    chk("ena_pos2", {16'd0, position}, 32'd0);
    chk("ena_err", {31'd0, err_out}, 32'd0);

    // Reset while a step is in flight drops it.
    @(negedge clk_in);
    {a_in, b_in} = 2'b01;
    repeat (3) @(negedge clk_in);
    reset_pulse();
    repeat (20) @(negedge clk_in);
    chk("midrst_pos", {16'd0, position}, 32'd0);
    chk("midrst_err", {31'd0, err_out}, 32'd0);
    chk("final_drain", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
